// File: rtl/led_pkg.sv
// -----------------------------------------------------------------------------
// led_pkg
// Shared constants and types for the LED comet-trail PWM block.
//   N_LEDS    : number of LED channels / width of the chaser pattern
//   PWM_BITS  : width of the PWM counter and of each brightness level
//   LEVEL_MAX : full brightness, loaded when a channel's pattern bit is lit
//   level_t   : one channel's brightness level / PWM compare value
// -----------------------------------------------------------------------------
package led_pkg;

   localparam int N_LEDS   = 10;
   localparam int PWM_BITS = 8;

   typedef logic [PWM_BITS-1:0] level_t;

   localparam level_t LEVEL_MAX = '1;

endpackage

// File: rtl/led_pwm_channel.sv
// -----------------------------------------------------------------------------
// led_pwm_channel
// One LED channel: synchronises its pattern bit, keeps a brightness level that
// loads to full while the bit is lit and decays in saturating steps once it
// drops, and compares that level against the shared PWM counter.
// Ports:
//   clk          : system clock
//   rst          : synchronous active-high reset
//   i_pat        : pattern bit from the chaser (asynchronous to clk)
//   i_decay_tick : one-cycle strobe, apply one decay step
//   i_pwm_cnt    : shared free-running PWM counter
//   o_led        : registered PWM drive for this LED
// -----------------------------------------------------------------------------
module led_pwm_channel
   import led_pkg::*;
#(
   parameter int DECAY_STEP = 32
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   i_pat,
   input  logic   i_decay_tick,
   input  level_t i_pwm_cnt,
   output logic   o_led
);

   localparam level_t STEP = level_t'(DECAY_STEP);

   logic   r_sync1;
   logic   r_sync2;
   level_t r_level;
   logic   r_led;

   // NOTE: every register here uses non-blocking assignments so r_sync2 sees
   // the previous r_sync1 and the compare sees the previous level; blocking
   // assignments would collapse the pipeline and change the latency.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_level <= '0;
         r_led   <= 1'b0;
      end else begin
         // NOTE: i_pat comes from another clock; two back-to-back flops give a
         // metastable first stage a full cycle to settle before r_sync2 is used.
         r_sync1 <= i_pat;
         r_sync2 <= r_sync1;

         // A lit bit beats a coinciding decay tick; decay saturates at zero.
         if (r_sync2) begin
            r_level <= LEVEL_MAX;
         end else if (i_decay_tick) begin
            r_level <= (r_level > STEP) ? (r_level - STEP) : '0;
         end

         // Level 0 never lights; LEVEL_MAX is dark only when the counter is at max.
         r_led <= (i_pwm_cnt < r_level);
      end
   end

   assign o_led = r_led;

endmodule

// File: rtl/led_trail_pwm.sv
// -----------------------------------------------------------------------------
// led_trail_pwm
// Turns the chaser's one-hot position pattern into a fading comet trail.
// Holds the shared PWM counter and decay-rate divider and one channel per LED.
// Ports:
//   clk      : system clock
//   rst      : synchronous active-high reset
//   pat_in   : position pattern from the chaser (asynchronous to clk)
//   led_out  : registered PWM drive, one bit per LED
//   pwm_wrap : registered one-cycle pulse per PWM period
// Channel count and PWM width come from led_pkg; decay rate and step size
// are set per instance.
// -----------------------------------------------------------------------------
module led_trail_pwm
   import led_pkg::*;
#(
   parameter int DECAY_DIV  = 131072,
   parameter int DECAY_STEP = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N_LEDS-1:0] pat_in,
   output logic [N_LEDS-1:0] led_out,
   output logic              pwm_wrap
);

   localparam int               DEC_W    = $clog2(DECAY_DIV);
   localparam logic [DEC_W-1:0] DEC_LAST = DEC_W'(DECAY_DIV - 1);

   level_t           r_pwm_cnt;
   logic [DEC_W-1:0] r_dec_cnt;
   logic             r_pwm_wrap;
   logic             w_decay_tick;

   // One decay step for every channel each time the divider completes a lap.
   assign w_decay_tick = (r_dec_cnt == DEC_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pwm_cnt  <= '0;
         r_dec_cnt  <= '0;
         r_pwm_wrap <= 1'b0;
      end else begin
         r_pwm_cnt  <= r_pwm_cnt + 1'b1;
         r_dec_cnt  <= w_decay_tick ? '0 : (r_dec_cnt + 1'b1);
         r_pwm_wrap <= (r_pwm_cnt == LEVEL_MAX);
      end
   end

   assign pwm_wrap = r_pwm_wrap;

   for (genvar g = 0; g < N_LEDS; g++) begin : g_chan
      led_pwm_channel #(
         .DECAY_STEP(DECAY_STEP)
      ) u_chan (
         .clk          (clk),
         .rst          (rst),
         .i_pat        (pat_in[g]),
         .i_decay_tick (w_decay_tick),
         .i_pwm_cnt    (r_pwm_cnt),
         .o_led        (led_out[g])
      );
   end

endmodule

// File: tb/tb_led_trail_pwm.sv
// -----------------------------------------------------------------------------
// tb_led_trail_pwm
// Self-checking bench for led_trail_pwm with DECAY_DIV=4, DECAY_STEP=64.
// The stimulus process queues the hand-computed per-channel high count for
// each PWM period; the monitor tallies led_out and compares on every pwm_wrap.
// Brightness levels are additionally spot-checked at hand-computed cycles.
// Cycle index k counts clk edges since reset release.
// -----------------------------------------------------------------------------
module tb_led_trail_pwm;
   import led_pkg::*;

   localparam int DIV    = 4;
   localparam int STEP   = 64;
   localparam int PERIOD = 1 << PWM_BITS;

   logic              clk    = 1'b0;
   logic              rst    = 1'b1;
   logic [N_LEDS-1:0] pat_in = '0;
   logic [N_LEDS-1:0] led_out;
   logic              pwm_wrap;

   int n_total = 0;
   int n_bad   = 0;
   int k       = 0;

   typedef struct {
      bit chk;
      int hi [N_LEDS];
   } exp_t;

   exp_t sb_q [$];

   led_trail_pwm #(
      .DECAY_DIV (DIV),
      .DECAY_STEP(STEP)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .pat_in  (pat_in),
      .led_out (led_out),
      .pwm_wrap(pwm_wrap)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_total++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0d want %0d (k=%0d)", name, act, req, k);
      end
   endtask

   function automatic level_t lvl(input int c);
      case (c)
         0:       return dut.g_chan[0].u_chan.r_level;
         1:       return dut.g_chan[1].u_chan.r_level;
         2:       return dut.g_chan[2].u_chan.r_level;
         3:       return dut.g_chan[3].u_chan.r_level;
         4:       return dut.g_chan[4].u_chan.r_level;
         5:       return dut.g_chan[5].u_chan.r_level;
         6:       return dut.g_chan[6].u_chan.r_level;
         7:       return dut.g_chan[7].u_chan.r_level;
         8:       return dut.g_chan[8].u_chan.r_level;
         9:       return dut.g_chan[9].u_chan.r_level;
         default: return '0;
      endcase
   endfunction

   // exp_lv packs bit9's level in the top byte down to bit0's in the bottom.
   task automatic check_lv(input string name, input logic [N_LEDS*PWM_BITS-1:0] exp_lv);
      for (int c = 0; c < N_LEDS; c++) begin
         check($sformatf("%s_lvl%0d", name, c), 64'(lvl(c)), 64'(exp_lv[c*PWM_BITS +: PWM_BITS]));
      end
   endtask

   // Expected high counts for one period: up to two non-zero channels.
   task automatic push_exp(input bit chk, input int ca, input int va, input int cb, input int vb);
      exp_t e;
      e.chk = chk;
      for (int c = 0; c < N_LEDS; c++) e.hi[c] = 0;
      if (ca >= 0) e.hi[ca] = va;
      if (cb >= 0) e.hi[cb] = vb;
      sb_q.push_back(e);
   endtask

   task automatic advance(input int target);
      while (k < target) begin
         @(posedge clk);
         #1;
         k++;
      end
   endtask

   // Monitor: tally highs per channel, compare on each pwm_wrap pulse.
   initial begin : monitor
      int   hi [N_LEDS];
      int   gap;
      bit   have_prev;
      exp_t e;
      gap       = 0;
      have_prev = 1'b0;
      for (int c = 0; c < N_LEDS; c++) hi[c] = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            for (int c = 0; c < N_LEDS; c++) hi[c] = 0;
            gap       = 0;
            have_prev = 1'b0;
         end else begin
            gap++;
            for (int c = 0; c < N_LEDS; c++) if (led_out[c] === 1'b1) hi[c]++;
            if (pwm_wrap === 1'b1) begin
               if (have_prev) check("wrap_spacing", 64'(gap), 64'(PERIOD));
               have_prev = 1'b1;
               gap       = 0;
               check("sb_pending", 64'(sb_q.size() > 0), 64'd1);
               if (sb_q.size() > 0) begin
                  e = sb_q.pop_front();
                  if (e.chk) begin
                     for (int c = 0; c < N_LEDS; c++) begin
                        check($sformatf("duty_ch%0d", c), 64'(hi[c]), 64'(e.hi[c]));
                     end
                     check("led_at_wrap", 64'(led_out), 64'd0);
                  end
               end
               for (int c = 0; c < N_LEDS; c++) hi[c] = 0;
            end
         end
      end
   end

   initial begin : watchdog
      #300000;
      $display("FAIL watchdog: simulation did not finish, k=%0d", k);
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int dk [7] = '{1795, 1796, 1799, 1800, 1804, 1808, 1830};
      int dv [7] = '{255,  191,  191,  127,  63,   0,    0};
      int n_wrap;

      // Reset held with every pattern bit lit: nothing may leak out.
      rst    = 1'b1;
      pat_in = '1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check("rst_led", 64'(led_out), 64'd0);
         check("rst_wrap", 64'(pwm_wrap), 64'd0);
      end
      rst    = 1'b0;
      pat_in = '0;
      k      = 0;

      // Dark for four full periods after release.
      for (int m = 0; m < 4; m++) push_exp(1'b1, -1, 0, -1, 0);

      // Full load on bit0: level reaches 255 on the 3rd edge after the change.
      advance(1024);
      pat_in = 10'b00_0000_0001;
      push_exp(1'b1, 0, 252, -1, 0);
      push_exp(1'b1, 0, 255, -1, 0);
      push_exp(1'b1, 0, 255, -1, 0);
      advance(1026);
      check("load_edge2", 64'(lvl(0)), 64'd0);
      advance(1027);
      check("load_edge3", 64'(lvl(0)), 64'd255);

      // Decay: 255 -> 191 -> 127 -> 63 -> 0 on ticks every 4 edges, then stays 0.
      advance(1792);
      pat_in = '0;
      push_exp(1'b1, 0, 16, -1, 0);
      push_exp(1'b1, -1, 0, -1, 0);
      for (int i = 0; i < 7; i++) begin
         advance(dk[i]);
         check($sformatf("decay_k%0d", dk[i]), 64'(lvl(0)), 64'(dv[i]));
      end

      // Collision: a one-cycle low pulse makes pat_s re-rise on a decay tick.
      advance(2304);
      pat_in = 10'b00_0000_0001;
      push_exp(1'b1, 0, 252, -1, 0);
      advance(2320);
      pat_in = '0;
      advance(2321);
      pat_in = 10'b00_0000_0001;
      advance(2323);
      check("pre_collision", 64'(lvl(0)), 64'd255);
      advance(2324);
      check("collision", 64'(lvl(0)), 64'd255);

      // Slow sweep: head moves one bit per PWM period, aligned to the period.
      for (int j = 1; j < N_LEDS; j++) begin
         advance(2560 + (j - 1) * PERIOD);
         pat_in    = '0;
         pat_in[j] = 1'b1;
         push_exp(1'b1, j, 252, j - 1, 16);
         if (j == 3) begin
            advance(3075);
            check("sweep_head3", 64'(lvl(3)), 64'd255);
         end
         if (j == 4) begin
            advance(3336);
            check("sweep_tail3_mid", 64'(lvl(3)), 64'd127);
            advance(3344);
            check("sweep_tail3_end", 64'(lvl(3)), 64'd0);
         end
      end
      advance(4864);
      push_exp(1'b1, 9, 255, -1, 0);

      // Fast sweep: head moves every decay tick, so the trail is visible.
      advance(5120);
      push_exp(1'b0, -1, 0, -1, 0);
      for (int j = 0; j < N_LEDS; j++) begin
         advance(5120 + 4 * j);
         if (j == 6) begin
            check_lv("trail_h5", {8'd0, 8'd0, 8'd0, 8'd0, 8'd255,
                                  8'd191, 8'd127, 8'd63, 8'd0, 8'd0});
         end
         pat_in    = '0;
         pat_in[j] = 1'b1;
      end
      advance(5160);
      check_lv("trail_h9", {8'd255, 8'd191, 8'd127, 8'd63, 8'd0,
                            8'd0, 8'd0, 8'd0, 8'd0, 8'd0});
      pat_in = '0;

      advance(5376);
      push_exp(1'b1, -1, 0, -1, 0);

      // Mid-operation reset while level[3] is 127.
      advance(5632);
      pat_in = 10'b00_0000_1000;
      push_exp(1'b1, 3, 252, -1, 0);
      advance(5888);
      pat_in = '0;
      push_exp(1'b1, -1, 0, -1, 0);
      advance(5896);
      check("pre_reset_lvl3", 64'(lvl(3)), 64'd127);
      rst = 1'b1;
      advance(5897);
      rst = 1'b0;
      check_lv("post_reset", '0);
      check("post_reset_led", 64'(led_out), 64'd0);
      check("post_reset_cnt", 64'(dut.r_pwm_cnt), 64'd0);
      check("post_reset_wrap", 64'(pwm_wrap), 64'd0);

      n_wrap = 0;
      for (int n = 1; n <= 300; n++) begin
         @(posedge clk);
         #1;
         k++;
         if (pwm_wrap === 1'b1) begin
            n_wrap = n;
            break;
         end
      end
      check("wrap_after_reset", 64'(n_wrap), 64'(PERIOD));

      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      check("sb_drained", 64'(sb_q.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
